renkon_ctrl_chain: RTL and testbench

//  Parametrised begin/valid/end control pipeline between the renkon core sequencer and its post-stages.

---
 rtl/renkon_ctrl_chain_pkg.sv | 21 ++
 rtl/renkon_ctrl_chain_if.sv | 32 +++
 rtl/renkon_ctrl_delay.sv | 37 +++
 rtl/renkon_ctrl_chain.sv | 126 ++++++++++++
 tb/tb_renkon_ctrl_chain.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/renkon_ctrl_chain_pkg.sv
// Shared types and defaults for the renkon begin/valid/end control chain.
package renkon_ctrl_chain_pkg;

   localparam int unsigned RENKON_NSTAGE = 4;
   localparam int unsigned RENKON_LATW   = 3;
   localparam int unsigned RENKON_CNTW   = 16;

   typedef enum logic [1:0] {
      S_CHAIN_IDLE  = 2'd0,
      S_CHAIN_RUN   = 2'd1,
      S_CHAIN_DRAIN = 2'd2
   } chain_state_t;

   // One cycle of control tokens travelling down the chain.
   typedef struct packed {
      logic bgn;
      logic vld;
      logic fin;
   } token_t;

endpackage

// File: rtl/renkon_ctrl_chain_if.sv
// Token, config and status bundle between the core sequencer and the control chain.
interface renkon_ctrl_chain_if
   import renkon_ctrl_chain_pkg::*;
#(
   parameter int unsigned NSTAGE = RENKON_NSTAGE,
   parameter int unsigned LATW   = RENKON_LATW,
   parameter int unsigned CNTW   = RENKON_CNTW
);
   logic                     in_begin;
   logic                     in_valid;
   logic                     in_end;
   logic [NSTAGE*LATW-1:0]   cfg_lat;
   logic [NSTAGE-1:0]        cfg_bypass;
   logic                     out_begin;
   logic                     out_valid;
   logic                     out_end;
   logic [NSTAGE-1:0]        stage_oe;
   logic                     busy;
   logic                     done;
   logic                     err;
   logic [CNTW-1:0]          beat_count;

   modport master (
      output in_begin, in_valid, in_end, cfg_lat, cfg_bypass,
      input  out_begin, out_valid, out_end, stage_oe, busy, done, err, beat_count
   );

   modport slave (
      input  in_begin, in_valid, in_end, cfg_lat, cfg_bypass,
      output out_begin, out_valid, out_end, stage_oe, busy, done, err, beat_count
   );
endinterface

// File: rtl/renkon_ctrl_delay.sv
// One post-stage: token shift register with a run-time tap and a transparent bypass.
module renkon_ctrl_delay
   import renkon_ctrl_chain_pkg::*;
#(
   parameter int unsigned LATW   = RENKON_LATW,
   parameter int unsigned MAXLAT = (2**LATW) - 1
) (
   input  logic            clk,
   input  logic            xrst,
   input  logic [LATW-1:0] lat,
   input  logic            bypass,
   input  token_t          d,
   output token_t          q
);

   logic [LATW-1:0] lat_sel;
   logic [LATW-1:0] depth;
   token_t          sr [MAXLAT];

   assign lat_sel = (lat == '0) ? LATW'(1) : lat;
   assign depth   = bypass ? '0 : lat_sel;

   // Slots at or beyond the tap have already been emitted, so they are zeroed to
   // keep a later, longer latency from replaying old tokens.
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         for (int k = 0; k < int'(MAXLAT); k++) sr[k] <= '0;
      end else begin
         sr[0] <= (depth != '0) ? d : '0;
         for (int k = 1; k < int'(MAXLAT); k++)
            sr[k] <= (LATW'(k) < depth) ? sr[k-1] : '0;
      end
   end

   assign q = bypass ? d : sr[lat_sel - LATW'(1)];

endmodule

// File: rtl/renkon_ctrl_chain.sv
// Chained post-stage token pipeline with run FSM, config latch, beat counter and sticky error.
module renkon_ctrl_chain
   import renkon_ctrl_chain_pkg::*;
#(
   parameter int unsigned NSTAGE = RENKON_NSTAGE,
   parameter int unsigned LATW   = RENKON_LATW,
   parameter int unsigned CNTW   = RENKON_CNTW
) (
   input  logic                clk,
   input  logic                xrst,
   renkon_ctrl_chain_if.slave  bus
);

   localparam int unsigned MAXLAT = (2**LATW) - 1;

   chain_state_t            state;
   chain_state_t            state_nxt;
   logic [NSTAGE*LATW-1:0]  lat_q;
   logic [NSTAGE*LATW-1:0]  lat_eff;
   logic [NSTAGE-1:0]       byp_q;
   logic [NSTAGE-1:0]       byp_eff;
   logic                    accept;
   logic                    complete;
   logic [CNTW-1:0]         cnt_q;
   logic [CNTW-1:0]         cnt_d;
   logic [CNTW-1:0]         beat_q;
   logic [CNTW-1:0]         beat_d;
   logic                    err_q;
   logic                    err_d;
   logic                    done_q;
   logic [NSTAGE-1:0]       oe;
   token_t                  tok [NSTAGE+1];

   assign accept = (state == S_CHAIN_IDLE) && bus.in_begin;

   // The accepting cycle already runs on the new config so the begin token sees it.
   assign lat_eff = accept ? bus.cfg_lat    : lat_q;
   assign byp_eff = accept ? bus.cfg_bypass : byp_q;

   assign tok[0] = {bus.in_begin && (state == S_CHAIN_IDLE), bus.in_valid, bus.in_end};

   for (genvar g = 0; g < int'(NSTAGE); g++) begin : g_stage
      renkon_ctrl_delay #(
         .LATW   (LATW),
         .MAXLAT (MAXLAT)
      ) u_delay (
         .clk    (clk),
         .xrst   (xrst),
         .lat    (lat_eff[g*LATW +: LATW]),
         .bypass (byp_eff[g]),
         .d      (tok[g]),
         .q      (tok[g+1])
      );
      assign oe[g] = tok[g+1].vld & ~byp_eff[g];
   end

   assign bus.out_begin  = tok[NSTAGE].bgn;
   assign bus.out_valid  = tok[NSTAGE].vld;
   assign bus.out_end    = tok[NSTAGE].fin;
   assign bus.stage_oe   = oe;
   assign bus.busy       = (state != S_CHAIN_IDLE);
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.beat_count = beat_q;

   // State and status registers.
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state  <= S_CHAIN_IDLE;
         lat_q  <= '0;
         byp_q  <= '1;
         cnt_q  <= '0;
         beat_q <= '0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt_q  <= cnt_d;
         beat_q <= beat_d;
         err_q  <= err_d;
         done_q <= complete;
         if (accept) begin
            lat_q <= bus.cfg_lat;
            byp_q <= bus.cfg_bypass;
         end
      end
   end

   // Next-state logic; DRAIN also exits on done_q for a run that finished in its accept cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_CHAIN_IDLE: begin
            if (bus.in_begin) state_nxt = bus.in_end ? S_CHAIN_DRAIN : S_CHAIN_RUN;
         end
         S_CHAIN_RUN: begin
            if (bus.in_end) state_nxt = bus.out_end ? S_CHAIN_IDLE : S_CHAIN_DRAIN;
         end
         S_CHAIN_DRAIN: begin
            if (bus.out_end || done_q) state_nxt = S_CHAIN_IDLE;
         end
         default: state_nxt = S_CHAIN_IDLE;
      endcase
   end

   // Counter, completion and error updates.
   always_comb begin
      complete = 1'b0;
      cnt_d    = cnt_q;
      beat_d   = beat_q;
      err_d    = err_q;
      if ((state == S_CHAIN_DRAIN) && bus.out_end)
         complete = 1'b1;
      if (((state == S_CHAIN_RUN) || accept) && bus.in_end && bus.out_end)
         complete = 1'b1;
      if (accept)
         cnt_d = CNTW'(bus.out_valid);
      else if ((state != S_CHAIN_IDLE) && bus.out_valid && (cnt_q != '1))
         cnt_d = cnt_q + CNTW'(1);
      if (complete)
         beat_d = cnt_d;
      if (bus.in_begin && (state != S_CHAIN_IDLE))
         err_d = 1'b1;
   end

endmodule

// File: tb/tb_renkon_ctrl_chain.sv
// Directed bench for renkon_ctrl_chain with a token/done scoreboard and a decoupled monitor.
module tb_renkon_ctrl_chain;

   localparam int unsigned NSTAGE = 4;
   localparam int unsigned LATW   = 3;
   localparam int unsigned CNTW   = 16;

   typedef struct {
      int   cyc;
      logic b;
      logic v;
      logic e;
   } exp_tok_t;

   typedef struct {
      int cyc;
      int beats;
   } exp_done_t;

   logic clk = 1'b0;
   logic xrst;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   bit   chk_oe12 = 1'b0;
   exp_tok_t  tq[$];
   exp_done_t dq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   renkon_ctrl_chain_if #(.NSTAGE(NSTAGE), .LATW(LATW), .CNTW(CNTW)) bus ();

   renkon_ctrl_chain #(.NSTAGE(NSTAGE), .LATW(LATW), .CNTW(CNTW)) dut (
      .clk  (clk),
      .xrst (xrst),
      .bus  (bus)
   );

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every output token cycle and every done pulse is matched against the scoreboard.
   always @(negedge clk) begin
      if (xrst === 1'b1) begin
         if (bus.out_begin || bus.out_valid || bus.out_end) begin
            if (tq.size() == 0) begin
               chk("tok_unexpected", int'({bus.out_begin, bus.out_valid, bus.out_end}), 0);
            end else begin
               exp_tok_t e;
               e = tq.pop_front();
               chk("tok_cycle", cyc, e.cyc);
               chk("tok_bits", int'({bus.out_begin, bus.out_valid, bus.out_end}),
                   int'({e.b, e.v, e.e}));
            end
         end
         if (bus.done) begin
            if (dq.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               exp_done_t d;
               d = dq.pop_front();
               chk("done_cycle", cyc, d.cyc);
               chk("beat_count", int'(bus.beat_count), d.beats);
            end
         end
         if (chk_oe12) chk("oe_bypassed", int'(bus.stage_oe[2:1]), 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] pack_lat(input int l0, input int l1, input int l2, input int l3);
      return {3'(l3), 3'(l2), 3'(l1), 3'(l0)};
   endfunction

   // nv == 0 drives begin+valid+end in one cycle; otherwise begin, then nv valid cycles with end on the last.
   task automatic drive_run(input logic [11:0] lat, input logic [3:0] byp, input int lat_tot,
                            input int nv, input int dup_at, input int chg_at,
                            input logic [11:0] chg_lat, output int t_end);
      exp_tok_t e;
      exp_done_t d;
      int last;
      last = (nv == 0) ? 0 : nv;
      for (int k = 0; k <= last; k++) begin
         tick();
         if (k == 0) begin
            bus.cfg_lat    = lat;
            bus.cfg_bypass = byp;
         end
         if (k == chg_at) bus.cfg_lat = chg_lat;
         bus.in_begin = (k == 0) || (k == dup_at);
         bus.in_valid = (nv == 0) || (k >= 1);
         bus.in_end   = (k == last);
         e.cyc = cyc + lat_tot;
         e.b   = (k == 0);
         e.v   = bus.in_valid;
         e.e   = bus.in_end;
         tq.push_back(e);
      end
      t_end = cyc;
      tick();
      bus.in_begin = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_end   = 1'b0;
      d.cyc   = t_end + lat_tot + 1;
      d.beats = (nv == 0) ? 1 : nv;
      dq.push_back(d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
      $fatal(1);
   end

   initial begin
      int te;
      int rst_cyc;
      logic [11:0] lat_a;
      lat_a = pack_lat(1, 2, 1, 3);
      xrst = 1'b0;
      bus.in_begin = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_end = 1'b0;
      bus.cfg_lat = '0;
      bus.cfg_bypass = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_err", int'(bus.err), 0);
      chk("rst_beat", int'(bus.beat_count), 0);
      chk("rst_out", int'({bus.out_begin, bus.out_valid, bus.out_end}), 0);
      chk("rst_oe", int'(bus.stage_oe), 0);
      tick();
      xrst = 1'b1;
      repeat (2) tick();

      // 1: all stages active, latency 1+2+1+3
      drive_run(lat_a, 4'b0000, 7, 10, -1, -1, '0, te);
      @(negedge clk);
      chk("t1_busy", int'(bus.busy), 1);
      repeat (12) tick();
      chk("t1_idle", int'(bus.busy), 0);

      // 2: stages 1 and 2 bypassed, latency 2+1
      chk_oe12 = 1'b1;
      drive_run(pack_lat(2, 5, 6, 1), 4'b0110, 3, 10, -1, -1, '0, te);
      repeat (8) tick();
      chk_oe12 = 1'b0;

      // 3: fully combinational chain, single-cycle run
      drive_run(pack_lat(0, 0, 0, 0), 4'b1111, 0, 0, -1, -1, '0, te);
      @(negedge clk);
      chk("t3_busy_on", int'(bus.busy), 1);
      tick();
      @(negedge clk);
      chk("t3_busy_off", int'(bus.busy), 0);
      chk("t3_err", int'(bus.err), 0);
      repeat (2) tick();

      // 4: stray begin during RUN is masked and flags err
      drive_run(lat_a, 4'b0000, 7, 10, 3, -1, '0, te);
      @(negedge clk);
      chk("t4_err_set", int'(bus.err), 1);
      repeat (12) tick();
      chk("t4_err_sticky", int'(bus.err), 1);

      // 5: mid-run latency change only takes effect on the next run
      drive_run(lat_a, 4'b0000, 7, 10, -1, 5, pack_lat(1, 1, 1, 1), te);
      repeat (12) tick();
      drive_run(pack_lat(1, 1, 1, 1), 4'b0000, 4, 6, -1, -1, '0, te);
      repeat (8) tick();
      chk("t5_err_sticky", int'(bus.err), 1);

      // 6: reset during DRAIN discards in-flight tokens and the pending done
      drive_run(lat_a, 4'b0000, 7, 10, -1, -1, '0, te);
      tick();
      xrst = 1'b0;
      rst_cyc = cyc;
      while (tq.size() > 0 && tq[$].cyc >= rst_cyc) void'(tq.pop_back());
      while (dq.size() > 0 && dq[$].cyc >= rst_cyc) void'(dq.pop_back());
      @(negedge clk);
      chk("t6_out", int'({bus.out_begin, bus.out_valid, bus.out_end}), 0);
      chk("t6_busy", int'(bus.busy), 0);
      chk("t6_done", int'(bus.done), 0);
      chk("t6_err", int'(bus.err), 0);
      chk("t6_beat", int'(bus.beat_count), 0);
      tick();
      xrst = 1'b1;
      repeat (10) tick();
      drive_run(lat_a, 4'b0000, 7, 10, -1, -1, '0, te);
      repeat (12) tick();

      chk("tok_q_empty", tq.size(), 0);
      chk("done_q_empty", dq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
